// File: rtl/fpu_float_to_int.sv
// fpu_float_to_int
//   Multi-cycle conversion of the custom 32-bit float (sign[31], exponent[30:25]
//   biased by 31, fraction[24:0] with implicit leading 1) to a 32-bit two's
//   complement integer, rounding toward zero and saturating when out of range.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-low
//   start_in    conversion request, sampled only in IDLE
//   op_in       float operand, captured on the accepting edge
//   data_out    signed integer result, held until the next completion
//   status_out  [3] overflow/saturated, [2] underflow, [1] inexact, [0] zero
//   busy_out    high while a conversion is in flight (SHIFT, FINISH)
//   done_out    one-cycle pulse when data_out/status_out update
//
// state  | meaning
// IDLE   | waiting for start_in; classifies op_in on the accepting edge
// SHIFT  | one-bit shift per cycle until the counter runs out
// FINISH | apply sign, build status, publish result
module fpu_float_to_int (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_in,
  input  logic [31:0] op_in,
  output logic [31:0] data_out,
  output logic [3:0]  status_out,
  output logic        busy_out,
  output logic        done_out
);

  localparam logic [5:0] BIAS = 6'd31;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t      state;
  logic [31:0] work;
  logic [4:0]  count;
  logic        shift_left;
  logic        sticky;
  logic        sign;
  logic        special;
  logic [31:0] special_data;
  logic [3:0]  special_status;

  // Classification of the incoming operand (used only on the accepting edge).
  logic [5:0]  exp_in;
  logic        cls_special;
  logic [31:0] cls_data;
  logic [3:0]  cls_status;
  logic        cls_left;
  logic [5:0]  cls_count;

  assign exp_in = op_in[30:25];

  always_comb begin
    cls_special = 1'b0;
    cls_data    = 32'd0;
    cls_status  = 4'b0000;
    cls_left    = 1'b0;
    cls_count   = 6'd0;
    if (exp_in == 6'd0) begin
      // Denormals are flushed: fraction ignored.
      cls_special = 1'b1;
      cls_status  = 4'b0001;
    end else if (exp_in < BIAS) begin
      cls_special = 1'b1;
      cls_status  = 4'b0111;
    end else if (exp_in >= BIAS + 6'd31) begin
      cls_special = 1'b1;
      // -2^31 is the only e >= 31 value that is exactly representable.
      if (op_in[31] && (op_in[24:0] == 25'd0) && (exp_in == BIAS + 6'd31)) begin
        cls_data   = 32'h8000_0000;
        cls_status = 4'b0000;
      end else begin
        cls_data   = op_in[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        cls_status = 4'b1000;
      end
    end else if (exp_in <= BIAS + 6'd25) begin
      cls_count = (BIAS + 6'd25) - exp_in;
    end else begin
      cls_left  = 1'b1;
      cls_count = exp_in - (BIAS + 6'd25);
    end
  end

  logic [31:0] fin_data;
  assign fin_data = sign ? (~work + 32'd1) : work;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      work           <= 32'd0;
      count          <= 5'd0;
      shift_left     <= 1'b0;
      sticky         <= 1'b0;
      sign           <= 1'b0;
      special        <= 1'b0;
      special_data   <= 32'd0;
      special_status <= 4'b0000;
      data_out       <= 32'd0;
      status_out     <= 4'b0000;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            work           <= {6'd0, 1'b1, op_in[24:0]};
            count          <= cls_count[4:0];
            shift_left     <= cls_left;
            sticky         <= 1'b0;
            sign           <= op_in[31];
            special        <= cls_special;
            special_data   <= cls_data;
            special_status <= cls_status;
            busy_out       <= 1'b1;
            state          <= (cls_special || cls_count == 6'd0) ? FINISH : SHIFT;
          end
        end
        SHIFT: begin
          if (shift_left) begin
            work <= work << 1;
          end else begin
            work   <= work >> 1;
            sticky <= sticky | work[0];
          end
          count <= count - 5'd1;
          if (count == 5'd1) state <= FINISH;
        end
        FINISH: begin
          if (special) begin
            data_out   <= special_data;
            status_out <= special_status;
          end else begin
            data_out   <= fin_data;
            status_out <= {2'b00, sticky, fin_data == 32'd0};
          end
          done_out <= 1'b1;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_float_to_int.sv
module tb_fpu_float_to_int;

  logic        clock;
  logic        reset;
  logic        start_in;
  logic [31:0] op_in;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic        busy_out;
  logic        done_out;

  int checks = 0;
  int passed = 0;

  fpu_float_to_int dut (
    .clock      (clock),
    .reset      (reset),
    .start_in   (start_in),
    .op_in      (op_in),
    .data_out   (data_out),
    .status_out (status_out),
    .busy_out   (busy_out),
    .done_out   (done_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] op;
    logic [31:0] data;
    logic [3:0]  status;
    int          latency;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one request, return result and the number of edges from accept to done.
  task automatic convert(input logic [31:0] op, output logic [31:0] d,
                         output logic [3:0] s, output int lat);
    @(negedge clock);
    start_in = 1'b1;
    op_in    = op;
    @(posedge clock);
    #1;
    start_in = 1'b0;
    op_in    = $urandom;
    check("busy_after_accept", {31'd0, busy_out}, 32'd1);
    lat = -1;
    d   = 32'd0;
    s   = 4'd0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (done_out) begin
        lat = i;
        d   = data_out;
        s   = status_out;
        break;
      end
    end
  endtask

  logic [31:0] d;
  logic [3:0]  s;
  int          lat;
  int          dones;
  logic [31:0] seen;

  initial begin
    vecs[0] = '{32'h3E00_0000, 32'h0000_0001, 4'b0000, 26};
    vecs[1] = '{32'hC2C0_0000, 32'hFFFF_FFFB, 4'b0010, 24};
    vecs[2] = '{32'h7A00_0000, 32'h4000_0000, 4'b0000, 6};
    vecs[3] = '{32'hFC00_0000, 32'h8000_0000, 4'b0000, 1};
    vecs[4] = '{32'h7E00_0000, 32'h7FFF_FFFF, 4'b1000, 1};
    vecs[5] = '{32'hFE00_0000, 32'h8000_0000, 4'b1000, 1};
    vecs[6] = '{32'h3C00_0000, 32'h0000_0000, 4'b0111, 1};
    vecs[7] = '{32'hBC00_0000, 32'h0000_0000, 4'b0111, 1};
    vecs[8] = '{32'h0000_0000, 32'h0000_0000, 4'b0001, 1};
    vecs[9] = '{32'h01FF_FFFF, 32'h0000_0000, 4'b0001, 1};

    reset    = 1'b0;
    start_in = 1'b0;
    op_in    = 32'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_data", data_out, 32'd0);
    check("reset_status", {28'd0, status_out}, 32'd0);
    check("reset_busy", {31'd0, busy_out}, 32'd0);
    check("reset_done", {31'd0, done_out}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      convert(vecs[i].op, d, s, lat);
      check($sformatf("vec%0d_data", i), d, vecs[i].data);
      check($sformatf("vec%0d_status", i), {28'd0, s}, {28'd0, vecs[i].status});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].latency);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_done_pulse", i), {30'd0, done_out, busy_out}, 32'd0);
    end

    // Request during SHIFT is dropped: only one done, carrying 1.
    @(negedge clock);
    start_in = 1'b1;
    op_in    = 32'h3E00_0000;
    @(posedge clock);
    #1;
    start_in = 1'b0;
    dones = 0;
    seen  = 32'hDEAD_BEEF;
    for (int i = 1; i <= 45; i++) begin
      if (i >= 3 && i <= 6) begin
        start_in = 1'b1;
        op_in    = 32'h7E00_0000;
      end else begin
        start_in = 1'b0;
      end
      @(posedge clock);
      #1;
      if (done_out) begin
        dones++;
        seen = data_out;
      end
    end
    start_in = 1'b0;
    check("ignored_start_dones", dones, 1);
    check("ignored_start_data", seen, 32'h0000_0001);

    // Start held across done: next request accepted on the done cycle.
    @(negedge clock);
    start_in = 1'b1;
    op_in    = 32'h7A00_0000;
    @(posedge clock);
    #1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (done_out) begin
        lat = i;
        break;
      end
    end
    check("b2b_first_latency", lat, 6);
    check("b2b_first_data", data_out, 32'h4000_0000);
    op_in = 32'hFC00_0000;
    @(posedge clock);
    #1;
    check("b2b_accepted_busy", {31'd0, busy_out}, 32'd1);
    check("b2b_accepted_done", {31'd0, done_out}, 32'd0);
    start_in = 1'b0;
    @(posedge clock);
    #1;
    check("b2b_second_done", {31'd0, done_out}, 32'd1);
    check("b2b_second_data", data_out, 32'h8000_0000);
    check("b2b_second_status", {28'd0, status_out}, 32'd0);

    // Reset in mid-conversion aborts without a done pulse.
    @(negedge clock);
    start_in = 1'b1;
    op_in    = 32'h3E00_0000;
    @(posedge clock);
    #1;
    start_in = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_data", data_out, 32'd0);
    check("abort_status", {28'd0, status_out}, 32'd0);
    check("abort_busy", {31'd0, busy_out}, 32'd0);
    check("abort_done", {31'd0, done_out}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (done_out) dones++;
    end
    check("abort_no_done", dones, 0);
    convert(32'h3E00_0000, d, s, lat);
    check("post_reset_data", d, 32'h0000_0001);
    check("post_reset_status", {28'd0, s}, 32'd0);
    check("post_reset_latency", lat, 26);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
